// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry defaults and the receiver state encoding.
package uart_pkg;

   // b_tick pulses per bit period (shared with uart_tx).
   localparam int OVERSAMPLE_DEF = 16;
   // Data bits per frame, LSB first.
   localparam int DATA_BITS_DEF  = 8;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to 1 so an
// idle-high serial line does not look like a start edge coming out of reset.
module uart_sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule : uart_sync_2ff

// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit validation, mid-bit data sampling,
// stop-bit check. Delivers a byte with a 1-clk rx_done strobe, or a 1-clk
// frame_err strobe when the stop bit is low (rx_data then keeps its old value).
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 b_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 rx_busy,
   output logic                 frame_err
);

   localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BIT_W = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;

   // Compare points: middle of the start bit, and one full bit period.
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   logic                 rx_s;

   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 busy_q;

   uart_sync_2ff u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (rx),
      .sync_o  (rx_s)
   );

   // Next-state logic: counters only move on b_tick; the IDLE start-edge check
   // runs every clock so no tick is lost between back-to-back frames.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               cnt_d   = '0;
               state_d = RX_START;
            end
         end
         RX_START: begin
            if (b_tick) begin
               if (cnt_q == HALF_M1) begin
                  cnt_d = '0;
                  if (!rx_s) begin
                     bit_d   = '0;
                     state_d = RX_DATA;
                  end else begin
                     // Line went back high before mid-start: glitch, drop it.
                     state_d = RX_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         RX_DATA: begin
            if (b_tick) begin
               if (cnt_q == FULL_M1) begin
                  cnt_d   = '0;
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (bit_q == LAST_BIT) begin
                     state_d = RX_STOP;
                  end else begin
                     bit_d = bit_q + BIT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         RX_STOP: begin
            if (b_tick) begin
               if (cnt_q == FULL_M1) begin
                  // Leave at mid-stop-bit so a following start edge is caught.
                  cnt_d   = '0;
                  state_d = RX_IDLE;
                  if (rx_s) begin
                     data_d = shift_q;
                     done_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = RX_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any frame in progress silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= (state_d != RX_IDLE);
      end
   end

   assign rx_data   = data_q;
   assign rx_done   = done_q;
   assign frame_err = err_q;
   assign rx_busy   = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a monitor
// pops and compares whenever rx_done or frame_err pulses.
module tb_uart_rx;

   logic       clk;
   logic       rst;
   logic       b_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_busy;
   logic       frame_err;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   int n_err = 0;
   int tick_div = 4;
   int tick_cnt = 0;
   logic [7:0] last_good = 8'h00;

   uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .b_tick    (b_tick),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .rx_busy   (rx_busy),
      .frame_err (frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Baud tick: changes on the falling edge, one pulse every tick_div clocks.
   initial begin
      b_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_cnt >= tick_div - 1) begin
            tick_cnt = 0;
            b_tick   = 1'b1;
         end else begin
            tick_cnt = tick_cnt + 1;
            b_tick   = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Wait for n b_tick-qualified rising edges, then step off the edge.
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (b_tick !== 1'b1) @(posedge clk);
      end
      #1;
   endtask

   // Drive one 8N1 frame; stop_ticks lets a bad stop bit be shortened.
   task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_ticks);
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_ticks(16);
      end
      rx = stop_val;
      wait_ticks(stop_ticks);
      rx = 1'b1;
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && (rx_done || frame_err)) begin
         exp_t e;
         check("done_err_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
         if (rx_done) n_done = n_done + 1;
         if (frame_err) n_err = n_err + 1;
         if (sb_q.size() == 0) begin
            check("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            $display("rx event: done=%0b err=%0b data=0x%02h (exp err=%0b data=0x%02h)",
                     rx_done, frame_err, rx_data, e.is_err, e.data);
            check("event_kind", {31'd0, frame_err}, {31'd0, e.is_err});
            check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
         end
      end
   end

   initial begin
      exp_t e;
      int   guard;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_outputs", {29'd0, rx_done, rx_busy, frame_err}, 32'd0);
      rst = 1'b0;
      wait_ticks(4);

      // 1. Good frame 0xA5.
      e.is_err = 1'b0; e.data = 8'hA5; sb_q.push_back(e);
      rx = 1'b0;
      wait_ticks(4);
      check("busy_in_frame", {31'd0, rx_busy}, 32'd1);
      rx = 1'b1;
      // Restart cleanly: let the short low be rejected first, then send the frame.
      wait_ticks(20);
      send_frame(8'hA5, 1'b1, 16);
      last_good = 8'hA5;
      wait_ticks(4);
      check("busy_falls", {31'd0, rx_busy}, 32'd0);
      check("data_after_a5", {24'd0, rx_data}, 32'hA5);

      // 2. Short low glitch: rejected at mid-start.
      rx = 1'b0;
      wait_ticks(4);
      rx = 1'b1;
      wait_ticks(16);
      check("glitch_idle", {31'd0, rx_busy}, 32'd0);
      check("glitch_data_hold", {24'd0, rx_data}, {24'd0, last_good});

      // 3. Frame 0x3C with a low stop bit.
      e.is_err = 1'b1; e.data = last_good; sb_q.push_back(e);
      send_frame(8'h3C, 1'b0, 10);
      wait_ticks(24);
      check("ferr_data_hold", {24'd0, rx_data}, 32'hA5);
      check("ferr_idle", {31'd0, rx_busy}, 32'd0);

      // 4. Back-to-back 0x00 then 0xFF.
      e.is_err = 1'b0; e.data = 8'h00; sb_q.push_back(e);
      e.is_err = 1'b0; e.data = 8'hFF; sb_q.push_back(e);
      send_frame(8'h00, 1'b1, 16);
      send_frame(8'hFF, 1'b1, 16);
      wait_ticks(4);
      check("b2b_last", {24'd0, rx_data}, 32'hFF);

      // 5. Reset during data bit 4 of 0x5A, then a clean 0x81.
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         rx = (8'h5A >> i) & 8'h01;
         wait_ticks(16);
      end
      rx = 1'b1;
      wait_ticks(8);
      #2 rst = 1'b1;
      #1;
      check("async_rst_data", {24'd0, rx_data}, 32'd0);
      check("async_rst_flags", {29'd0, rx_done, rx_busy, frame_err}, 32'd0);
      wait_ticks(2);
      rst = 1'b0;
      wait_ticks(20);
      check("post_rst_idle", {31'd0, rx_busy}, 32'd0);
      e.is_err = 1'b0; e.data = 8'h81; sb_q.push_back(e);
      send_frame(8'h81, 1'b1, 16);
      wait_ticks(4);
      check("after_rst_81", {24'd0, rx_data}, 32'h81);

      // 6. Loopback-style stream of all byte values, tick every clock.
      tick_div = 1;
      wait_ticks(4);
      for (int v = 0; v < 256; v++) begin
         e.is_err = 1'b0; e.data = v[7:0]; sb_q.push_back(e);
         send_frame(v[7:0], 1'b1, 16);
      end

      guard = 0;
      while (sb_q.size() != 0 && guard < 500) begin
         @(posedge clk);
         guard = guard + 1;
      end
      #1;
      check("scoreboard_drained", sb_q.size(), 32'd0);
      check("total_done", n_done, 32'd260);
      check("total_ferr", n_err, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_uart_rx
